reg_commit_scheduler: RTL and testbench

Sequences all updates into the architectural register file. It sits between the reorder buffer and dispatcher on one side and the register file's value-write, tag-write and tag-clear ports on the other. Commit writes are buffered in a small FIFO and retired one per cycle. Rename tag writes are forwarded directly. On a rollback, every already-committed value is drained to the register file before a single clear-all-tags pulse is issued.

---
 rtl/reg_commit_scheduler.sv | 120 ++++++++++++
 tb/tb_reg_commit_scheduler.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_commit_scheduler.sv
// Commit/rename write sequencer for the architectural register file.
// Commits retire through a small FIFO; a rollback drains it and then clears all tags once.
module reg_commit_scheduler #(
    parameter int DEPTH  = 4,
    parameter int REG_W  = 5,
    parameter int ROB_W  = 4,
    parameter int DATA_W = 32
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      rdy_in,
    input  logic                      commit_valid_in,
    input  logic [REG_W-1:0]          commit_rd_in,
    input  logic [DATA_W-1:0]         commit_data_in,
    input  logic [ROB_W-1:0]          commit_rob_in,
    output logic                      commit_ready_out,
    input  logic                      rename_valid_in,
    input  logic [REG_W-1:0]          rename_rd_in,
    input  logic [ROB_W-1:0]          rename_rob_in,
    output logic                      rename_ready_out,
    input  logic                      rollback_in,
    output logic                      rf_wr_en_out,
    output logic [REG_W-1:0]          rf_wr_rd_out,
    output logic [DATA_W-1:0]         rf_wr_data_out,
    output logic [ROB_W-1:0]          rf_wr_rob_out,
    output logic                      rf_tag_en_out,
    output logic [REG_W-1:0]          rf_tag_rd_out,
    output logic [ROB_W-1:0]          rf_tag_rob_out,
    output logic                      rf_clear_tags_out,
    output logic [$clog2(DEPTH):0]    count_out
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [REG_W-1:0]  mem_rd   [DEPTH];
    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [ROB_W-1:0]  mem_rob  [DEPTH];

    logic commit_acc, enq, deq, rename_acc;

    // A rename arriving with the flush is younger than it, so it is refused that cycle.
    always_comb begin
        commit_ready_out = (state == RUN) && (count_out < FULL);
        rename_ready_out = (state == RUN) && !rollback_in;
        commit_acc       = commit_valid_in && commit_ready_out && rdy_in;
        enq              = commit_acc && (commit_rd_in != '0);
        deq              = rdy_in && (count_out != '0) && (state != CLEAR);
        rename_acc       = rename_valid_in && rename_ready_out && rdy_in
                           && (rename_rd_in != '0);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (rollback_in) state_nxt = DRAIN;
            DRAIN:   if (count_out == '0) state_nxt = CLEAR;
            CLEAR:   state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state             <= RUN;
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            count_out         <= '0;
            rf_wr_en_out      <= 1'b0;
            rf_wr_rd_out      <= '0;
            rf_wr_data_out    <= '0;
            rf_wr_rob_out     <= '0;
            rf_tag_en_out     <= 1'b0;
            rf_tag_rd_out     <= '0;
            rf_tag_rob_out    <= '0;
            rf_clear_tags_out <= 1'b0;
        end else if (rdy_in) begin
            state <= state_nxt;
            if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
            if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({enq, deq})
                2'b10:   count_out <= count_out + CNT_W'(1);
                2'b01:   count_out <= count_out - CNT_W'(1);
                default: count_out <= count_out;
            endcase
            rf_wr_en_out <= deq;
            if (deq) begin
                rf_wr_rd_out   <= mem_rd[rd_ptr];
                rf_wr_data_out <= mem_data[rd_ptr];
                rf_wr_rob_out  <= mem_rob[rd_ptr];
            end
            rf_tag_en_out <= rename_acc;
            if (rename_acc) begin
                rf_tag_rd_out  <= rename_rd_in;
                rf_tag_rob_out <= rename_rob_in;
            end
            rf_clear_tags_out <= (state_nxt == CLEAR);
        end
    end

    // Payload storage carries no reset; only occupancy decides what is valid.
    always_ff @(posedge clk_in) begin
        if (enq) begin
            mem_rd[wr_ptr]   <= commit_rd_in;
            mem_data[wr_ptr] <= commit_data_in;
            mem_rob[wr_ptr]  <= commit_rob_in;
        end
    end

endmodule

// File: tb/tb_reg_commit_scheduler.sv
// Bench for reg_commit_scheduler: directed vector table, hand sequences for
// stall/rollback/reset corners, and randomized traffic against a queue-based model.
module tb_reg_commit_scheduler;

    localparam int DEPTH  = 4;
    localparam int REG_W  = 5;
    localparam int ROB_W  = 4;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 3;
    localparam logic [31:0] DB = 32'hDEADBEEF;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic              rdy_in;
    logic              commit_valid_in;
    logic [REG_W-1:0]  commit_rd_in;
    logic [DATA_W-1:0] commit_data_in;
    logic [ROB_W-1:0]  commit_rob_in;
    logic              commit_ready_out;
    logic              rename_valid_in;
    logic [REG_W-1:0]  rename_rd_in;
    logic [ROB_W-1:0]  rename_rob_in;
    logic              rename_ready_out;
    logic              rollback_in;
    logic              rf_wr_en_out;
    logic [REG_W-1:0]  rf_wr_rd_out;
    logic [DATA_W-1:0] rf_wr_data_out;
    logic [ROB_W-1:0]  rf_wr_rob_out;
    logic              rf_tag_en_out;
    logic [REG_W-1:0]  rf_tag_rd_out;
    logic [ROB_W-1:0]  rf_tag_rob_out;
    logic              rf_clear_tags_out;
    logic [CNT_W-1:0]  count_out;

    reg_commit_scheduler #(.DEPTH(DEPTH), .REG_W(REG_W), .ROB_W(ROB_W), .DATA_W(DATA_W)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .commit_valid_in(commit_valid_in), .commit_rd_in(commit_rd_in),
        .commit_data_in(commit_data_in), .commit_rob_in(commit_rob_in),
        .commit_ready_out(commit_ready_out),
        .rename_valid_in(rename_valid_in), .rename_rd_in(rename_rd_in),
        .rename_rob_in(rename_rob_in), .rename_ready_out(rename_ready_out),
        .rollback_in(rollback_in),
        .rf_wr_en_out(rf_wr_en_out), .rf_wr_rd_out(rf_wr_rd_out),
        .rf_wr_data_out(rf_wr_data_out), .rf_wr_rob_out(rf_wr_rob_out),
        .rf_tag_en_out(rf_tag_en_out), .rf_tag_rd_out(rf_tag_rd_out),
        .rf_tag_rob_out(rf_tag_rob_out), .rf_clear_tags_out(rf_clear_tags_out),
        .count_out(count_out)
    );

    always #5 clk_in = ~clk_in;

    int n_chk  = 0;
    int n_fail = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
        logic [ROB_W-1:0]  rob;
    } ent_t;

    ent_t             mq[$];
    int               m_mode;   // 0 accepting, 1 flushing, 2 tag-clear cycle
    logic             m_wen;
    ent_t             m_w;
    logic             m_ten;
    logic [REG_W-1:0] m_trd;
    logic [ROB_W-1:0] m_trob;
    logic             m_clr;

    task automatic m_reset();
        mq.delete();
        m_mode = 0;
        m_wen  = 1'b0;
        m_w    = '0;
        m_ten  = 1'b0;
        m_trd  = '0;
        m_trob = '0;
        m_clr  = 1'b0;
    endtask

    task automatic m_step();
        int   sz;
        logic c_acc, r_acc;
        sz    = mq.size();
        c_acc = commit_valid_in && (m_mode == 0) && (sz < DEPTH);
        r_acc = rename_valid_in && (m_mode == 0) && !rollback_in && (rename_rd_in != 0);
        m_wen = (sz > 0) && (m_mode != 2);
        if (m_wen) m_w = mq.pop_front();
        if (c_acc && commit_rd_in != 0) mq.push_back({commit_rd_in, commit_data_in, commit_rob_in});
        m_ten = r_acc;
        if (r_acc) begin
            m_trd  = rename_rd_in;
            m_trob = rename_rob_in;
        end
        if (m_mode == 0) begin
            if (rollback_in) m_mode = 1;
        end else if (m_mode == 1) begin
            if (sz == 0) m_mode = 2;
        end else begin
            m_mode = 0;
        end
        m_clr = (m_mode == 2);
    endtask

    always @(posedge clk_in or posedge rst_in) begin
        if (rst_in) m_reset();
        else if (rdy_in) m_step();
    end

    always @(negedge clk_in) begin
        if (chk_en) begin
            chk("m_wen", rf_wr_en_out, m_wen);
            chk("m_wr", {rf_wr_rd_out, rf_wr_data_out, rf_wr_rob_out}, m_w);
            chk("m_tag", {rf_tag_en_out, rf_tag_rd_out, rf_tag_rob_out}, {m_ten, m_trd, m_trob});
            chk("m_clr", rf_clear_tags_out, m_clr);
            chk("m_cnt", count_out, mq.size());
            chk("m_crdy", commit_ready_out, (m_mode == 0) && (mq.size() < DEPTH));
            chk("m_rrdy", rename_ready_out, (m_mode == 0) && !rollback_in);
        end
    end

    // Register-file side: a held strobe lands once, at the next enabled edge.
    ent_t wlog[$];
    always @(posedge clk_in) begin
        if (!rst_in && rdy_in && rf_wr_en_out)
            wlog.push_back({rf_wr_rd_out, rf_wr_data_out, rf_wr_rob_out});
    end

    // ---------------- directed vector table ----------------
    typedef struct packed {
        logic rdy; logic cv; logic [4:0] crd; logic [31:0] cdata; logic [3:0] crob;
        logic rv; logic [4:0] rrd; logic [3:0] rrob; logic rb;
        logic e_crdy; logic e_rrdy;
        logic e_wen; logic [4:0] e_wrd; logic [31:0] e_wdata; logic [3:0] e_wrob;
        logic e_ten; logic [4:0] e_trd; logic [3:0] e_trob; logic e_clr; logic [2:0] e_cnt;
    } vec_t;

    localparam int NV = 16;
    vec_t tbl [NV];

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        rdy_in = 1'b1; commit_valid_in = 1'b0; commit_rd_in = '0; commit_data_in = '0;
        commit_rob_in = '0; rename_valid_in = 1'b0; rename_rd_in = '0; rename_rob_in = '0;
        rollback_in = 1'b0;
    endtask

    task automatic commit(input logic [4:0] rd, input logic [31:0] d, input logic [3:0] rob);
        commit_valid_in = 1'b1; commit_rd_in = rd; commit_data_in = d; commit_rob_in = rob;
    endtask

    ent_t exp_b [5];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = '{1'b1,1'b1,5'd3,DB,4'd5,      1'b0,5'd0,4'd0,1'b0, 1'b1,1'b1, 1'b0,5'd0,32'd0,4'd0,     1'b0,5'd0,4'd0,1'b0,3'd1};
        tbl[1]  = '{1'b1,1'b0,5'd0,32'd0,4'd0,   1'b0,5'd0,4'd0,1'b0, 1'b1,1'b1, 1'b1,5'd3,DB,4'd5,        1'b0,5'd0,4'd0,1'b0,3'd0};
        tbl[2]  = '{1'b1,1'b0,5'd0,32'd0,4'd0,   1'b0,5'd0,4'd0,1'b0, 1'b1,1'b1, 1'b0,5'd3,DB,4'd5,        1'b0,5'd0,4'd0,1'b0,3'd0};
        tbl[3]  = '{1'b1,1'b0,5'd0,32'd0,4'd0,   1'b1,5'd7,4'd9,1'b0, 1'b1,1'b1, 1'b0,5'd3,DB,4'd5,        1'b1,5'd7,4'd9,1'b0,3'd0};
        tbl[4]  = '{1'b1,1'b0,5'd0,32'd0,4'd0,   1'b1,5'd0,4'd2,1'b0, 1'b1,1'b1, 1'b0,5'd3,DB,4'd5,        1'b0,5'd7,4'd9,1'b0,3'd0};
        tbl[5]  = '{1'b1,1'b1,5'd0,32'h1234,4'd6, 1'b0,5'd0,4'd0,1'b0, 1'b1,1'b1, 1'b0,5'd3,DB,4'd5,       1'b0,5'd7,4'd9,1'b0,3'd0};
        tbl[6]  = '{1'b1,1'b0,5'd0,32'd0,4'd0,   1'b0,5'd0,4'd0,1'b0, 1'b1,1'b1, 1'b0,5'd3,DB,4'd5,        1'b0,5'd7,4'd9,1'b0,3'd0};
        tbl[7]  = '{1'b1,1'b1,5'd1,32'h11,4'd1,  1'b0,5'd0,4'd0,1'b0, 1'b1,1'b1, 1'b0,5'd3,DB,4'd5,        1'b0,5'd7,4'd9,1'b0,3'd1};
        tbl[8]  = '{1'b1,1'b1,5'd2,32'h22,4'd2,  1'b0,5'd0,4'd0,1'b0, 1'b1,1'b1, 1'b1,5'd1,32'h11,4'd1,    1'b0,5'd7,4'd9,1'b0,3'd1};
        tbl[9]  = '{1'b1,1'b1,5'd4,32'h44,4'd3,  1'b0,5'd0,4'd0,1'b0, 1'b1,1'b1, 1'b1,5'd2,32'h22,4'd2,    1'b0,5'd7,4'd9,1'b0,3'd1};
        tbl[10] = '{1'b1,1'b1,5'd5,32'h55,4'd4,  1'b1,5'd6,4'd7,1'b1, 1'b1,1'b0, 1'b1,5'd4,32'h44,4'd3,    1'b0,5'd7,4'd9,1'b0,3'd1};
        tbl[11] = '{1'b1,1'b0,5'd0,32'd0,4'd0,   1'b0,5'd0,4'd0,1'b1, 1'b0,1'b0, 1'b1,5'd5,32'h55,4'd4,    1'b0,5'd7,4'd9,1'b0,3'd0};
        tbl[12] = '{1'b1,1'b0,5'd0,32'd0,4'd0,   1'b0,5'd0,4'd0,1'b0, 1'b0,1'b0, 1'b0,5'd5,32'h55,4'd4,    1'b0,5'd7,4'd9,1'b1,3'd0};
        tbl[13] = '{1'b0,1'b0,5'd0,32'd0,4'd0,   1'b0,5'd0,4'd0,1'b0, 1'b0,1'b0, 1'b0,5'd5,32'h55,4'd4,    1'b0,5'd7,4'd9,1'b1,3'd0};
        tbl[14] = '{1'b1,1'b1,5'd6,32'h66,4'd8,  1'b0,5'd0,4'd0,1'b1, 1'b0,1'b0, 1'b0,5'd5,32'h55,4'd4,    1'b0,5'd7,4'd9,1'b0,3'd0};
        tbl[15] = '{1'b1,1'b0,5'd0,32'd0,4'd0,   1'b0,5'd0,4'd0,1'b0, 1'b1,1'b1, 1'b0,5'd5,32'h55,4'd4,    1'b0,5'd7,4'd9,1'b0,3'd0};

        rst_in = 1'b1;
        idle();
        @(posedge clk_in);
        #1;
        chk_en = 1'b1;

        @(negedge clk_in);
        chk("rst_wen", rf_wr_en_out, 1'b0);
        chk("rst_wr", {rf_wr_rd_out, rf_wr_data_out, rf_wr_rob_out}, '0);
        chk("rst_tag", {rf_tag_en_out, rf_tag_rd_out, rf_tag_rob_out}, '0);
        chk("rst_clr", rf_clear_tags_out, 1'b0);
        chk("rst_cnt", count_out, 0);
        chk("rst_rdy", {commit_ready_out, rename_ready_out}, 2'b11);
        step();
        rst_in = 1'b0;

        for (int i = 0; i < NV; i++) begin
            rdy_in = tbl[i].rdy;
            commit_valid_in = tbl[i].cv; commit_rd_in = tbl[i].crd;
            commit_data_in = tbl[i].cdata; commit_rob_in = tbl[i].crob;
            rename_valid_in = tbl[i].rv; rename_rd_in = tbl[i].rrd; rename_rob_in = tbl[i].rrob;
            rollback_in = tbl[i].rb;
            @(negedge clk_in);
            chk($sformatf("v%0d_crdy", i), commit_ready_out, tbl[i].e_crdy);
            chk($sformatf("v%0d_rrdy", i), rename_ready_out, tbl[i].e_rrdy);
            step();
            chk($sformatf("v%0d_wr", i), {rf_wr_en_out, rf_wr_rd_out, rf_wr_data_out, rf_wr_rob_out},
                {tbl[i].e_wen, tbl[i].e_wrd, tbl[i].e_wdata, tbl[i].e_wrob});
            chk($sformatf("v%0d_tag", i), {rf_tag_en_out, rf_tag_rd_out, rf_tag_rob_out},
                {tbl[i].e_ten, tbl[i].e_trd, tbl[i].e_trob});
            chk($sformatf("v%0d_clr", i), rf_clear_tags_out, tbl[i].e_clr);
            chk($sformatf("v%0d_cnt", i), count_out, tbl[i].e_cnt);
        end

        // Back-to-back commits with a 3-cycle stall while a write strobe is held.
        idle();
        wlog.delete();
        exp_b[0] = {5'd10, 32'hA0A0_0001, 4'd1};
        exp_b[1] = {5'd11, 32'hB1B1_0002, 4'd2};
        exp_b[2] = {5'd12, 32'hC2C2_0003, 4'd3};
        exp_b[3] = {5'd13, 32'hD3D3_0004, 4'd4};
        exp_b[4] = {5'd14, 32'hE4E4_0005, 4'd5};
        commit(exp_b[0].rd, exp_b[0].data, exp_b[0].rob); step();
        commit(exp_b[1].rd, exp_b[1].data, exp_b[1].rob); step();
        rdy_in = 1'b0;
        commit(exp_b[2].rd, exp_b[2].data, exp_b[2].rob);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("b_hold_wr", {rf_wr_en_out, rf_wr_rd_out}, {1'b1, exp_b[0].rd});
            chk("b_hold_cnt", count_out, 1);
        end
        rdy_in = 1'b1;
        step();
        commit(exp_b[3].rd, exp_b[3].data, exp_b[3].rob); step();
        commit(exp_b[4].rd, exp_b[4].data, exp_b[4].rob); step();
        idle();
        repeat (3) step();
        chk("b_nwrites", wlog.size(), 5);
        for (int k = 0; k < 5; k++) begin
            if (k < wlog.size()) chk($sformatf("b_write%0d", k), wlog[k], exp_b[k]);
        end

        // Asynchronous reset in the middle of a drain.
        commit(5'd9, 32'h99, 4'd9); step();
        commit(5'd8, 32'h88, 4'd10); rollback_in = 1'b1; step();
        chk("c_drain_wen", rf_wr_en_out, 1'b1);
        chk("c_drain_rdy", {commit_ready_out, rename_ready_out}, 2'b00);
        idle();
        #2;
        rst_in = 1'b1;
        #1;
        chk("c_rst_wr", {rf_wr_en_out, rf_wr_rd_out, rf_wr_data_out, rf_wr_rob_out}, '0);
        chk("c_rst_tag", {rf_tag_en_out, rf_tag_rd_out, rf_tag_rob_out}, '0);
        chk("c_rst_clr", rf_clear_tags_out, 1'b0);
        chk("c_rst_cnt", count_out, 0);
        chk("c_rst_rdy", {commit_ready_out, rename_ready_out}, 2'b11);
        step();
        rst_in = 1'b0;
        repeat (3) step();
        chk("c_after_wen", {rf_wr_en_out, rf_clear_tags_out}, 2'b00);
        chk("c_after_cnt", count_out, 0);

        // Randomized traffic; the model checker compares every cycle.
        for (int n = 0; n < 2000; n++) begin
            rdy_in          = ($urandom_range(0, 3) != 0);
            commit_valid_in = $urandom_range(0, 1) != 0;
            commit_rd_in    = REG_W'($urandom_range(0, 7));
            commit_data_in  = $urandom;
            commit_rob_in   = ROB_W'($urandom_range(0, 15));
            rename_valid_in = ($urandom_range(0, 4) < 2);
            rename_rd_in    = REG_W'($urandom_range(0, 7));
            rename_rob_in   = ROB_W'($urandom_range(0, 15));
            rollback_in     = ($urandom_range(0, 19) == 0);
            step();
        end
        idle();
        repeat (8) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
